// File: rtl/freq_period_meter_pkg.sv
// Shared definitions for the period/duty meter: volume code range, default widths and FSM states.
package freq_period_meter_pkg;

  localparam int unsigned        VOL_W     = 4;
  localparam logic [VOL_W-1:0]   VOL_MAX   = 4'hF;
  localparam int unsigned        DEF_CNT_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_LOST  = 2'd2
  } meter_state_t;

endpackage

// File: rtl/freq_period_meter_edge_sync.sv
// Multi-flop synchroniser for an asynchronous input plus a registered rising-edge detector.
module edge_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic in_sig,
  output logic level,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   level_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q  <= '0;
      level_d <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], in_sig};
      level_d <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~level_d;

endmodule

// File: rtl/freq_period_meter.sv
// Recovers the averaged period and duty-derived volume code of a square wave, flags loss of signal.
module freq_period_meter
  import freq_period_meter_pkg::*;
#(
  parameter int unsigned CNT_W        = DEF_CNT_W,
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned AVG_LOG2     = 2,
  parameter int unsigned MIN_PERIOD   = 32,
  parameter int unsigned TIMEOUT_CLKS = 4194304
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_sig,
  input  logic             enable,
  output logic [CNT_W-1:0] clks_per_period,
  output logic [VOL_W-1:0] volume,
  output logic             period_valid,
  output logic             signal_present
);

  localparam int unsigned      SUM_W  = CNT_W + AVG_LOG2;
  localparam int unsigned      EXT_W  = SUM_W + 16;
  localparam logic [AVG_LOG2:0] N_LAST = (AVG_LOG2+1)'((1 << AVG_LOG2) - 1);

  meter_state_t      state;
  logic              sig_level;
  logic              sig_rise;
  logic [CNT_W-1:0]  per_cnt;
  logic [CNT_W-1:0]  hi_cnt;
  logic [CNT_W:0]    per_len;
  logic              accept;
  logic [SUM_W-1:0]  per_sum;
  logic [SUM_W-1:0]  hi_sum;
  logic [SUM_W-1:0]  per_snap;
  logic [SUM_W-1:0]  hi_snap;
  logic [AVG_LOG2:0] n;
  logic              busy;
  logic [3:0]        k;
  logic [EXT_W-1:0]  hi_shift;
  logic              calc_done;

  edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk    (clk),
    .reset  (reset),
    .in_sig (in_sig),
    .level  (sig_level),
    .rise   (sig_rise)
  );

  always_comb begin
    per_len   = {1'b0, per_cnt} + (CNT_W+1)'(1);
    accept    = (state == ST_ARMED) && sig_rise && (per_len >= (CNT_W+1)'(MIN_PERIOD));
    hi_shift  = EXT_W'(hi_snap) << ({1'b0, k} + 5'd1);
    calc_done = (hi_shift >= EXT_W'(per_snap)) || (k == 4'd15);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= ST_IDLE;
      per_cnt         <= '0;
      hi_cnt          <= '0;
      per_sum         <= '0;
      hi_sum          <= '0;
      per_snap        <= '0;
      hi_snap         <= '0;
      n               <= '0;
      busy            <= 1'b0;
      k               <= '0;
      clks_per_period <= '0;
      volume          <= '0;
      period_valid    <= 1'b0;
      signal_present  <= 1'b0;
    end else begin
      period_valid <= 1'b0;
      if (!enable) begin
        state   <= ST_IDLE;
        per_cnt <= '0;
        hi_cnt  <= '0;
        per_sum <= '0;
        hi_sum  <= '0;
        n       <= '0;
        busy    <= 1'b0;
        k       <= '0;
      end else begin
        // Duty search runs alongside ARMED; a window closing below re-seeds it afterwards.
        if (busy && state != ST_LOST) begin
          if (calc_done) begin
            clks_per_period <= CNT_W'(per_snap >> AVG_LOG2);
            volume          <= VOL_MAX - k;
            signal_present  <= 1'b1;
            period_valid    <= 1'b1;
            busy            <= 1'b0;
          end else begin
            k <= k + 4'd1;
          end
        end

        case (state)
          ST_IDLE: begin
            per_cnt <= '0;
            hi_cnt  <= '0;
            if (sig_rise) begin
              state  <= ST_ARMED;
              hi_cnt <= CNT_W'(1);
            end
          end

          ST_ARMED: begin
            if (accept) begin
              // hi_cnt restarts at 1: the rise cycle itself is the first high clk of the new period.
              per_cnt <= '0;
              hi_cnt  <= CNT_W'(1);
              if (n == N_LAST) begin
                per_snap <= per_sum + SUM_W'(per_len);
                hi_snap  <= hi_sum + SUM_W'(hi_cnt);
                per_sum  <= '0;
                hi_sum   <= '0;
                n        <= '0;
                busy     <= 1'b1;
                k        <= '0;
              end else begin
                per_sum <= per_sum + SUM_W'(per_len);
                hi_sum  <= hi_sum + SUM_W'(hi_cnt);
                n       <= n + (AVG_LOG2+1)'(1);
              end
            end else if (per_cnt == CNT_W'(TIMEOUT_CLKS)) begin
              state <= ST_LOST;
            end else begin
              per_cnt <= per_cnt + CNT_W'(1);
              hi_cnt  <= hi_cnt + CNT_W'(sig_level);
            end
          end

          ST_LOST: begin
            clks_per_period <= '0;
            volume          <= '0;
            signal_present  <= 1'b0;
            period_valid    <= 1'b1;
            busy            <= 1'b0;
            k               <= '0;
            per_sum         <= '0;
            hi_sum          <= '0;
            n               <= '0;
            per_cnt         <= '0;
            hi_cnt          <= '0;
            state           <= ST_IDLE;
          end

          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_freq_period_meter.sv
// Scoreboard bench for freq_period_meter: stimulus queues expected results, a monitor checks each period_valid.
module tb_freq_period_meter;
  import freq_period_meter_pkg::*;

  localparam int unsigned CNT_W = 32;
  localparam int unsigned TMO   = 600;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_sig;
  logic             enable;
  logic [CNT_W-1:0] clks_per_period;
  logic [VOL_W-1:0] volume;
  logic             period_valid;
  logic             signal_present;

  freq_period_meter #(
    .CNT_W        (CNT_W),
    .SYNC_STAGES  (2),
    .AVG_LOG2     (2),
    .MIN_PERIOD   (32),
    .TIMEOUT_CLKS (TMO)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .in_sig          (in_sig),
    .enable          (enable),
    .clks_per_period (clks_per_period),
    .volume          (volume),
    .period_valid    (period_valid),
    .signal_present  (signal_present)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] cpp;
    logic [3:0]  vol;
    logic        present;
  } exp_t;

  exp_t        exp_q[$];
  int          tests = 0;
  int          fails = 0;
  int unsigned cyc = 0;
  int unsigned last_rise_cyc = 0;
  int unsigned last_valid_cyc = 0;
  int unsigned valid_count = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every period_valid pulse must match the oldest queued expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (period_valid === 1'b1) begin
        exp_t e;
        last_valid_cyc = cyc;
        valid_count++;
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_valid: got pulse cpp=%0d vol=%0d, expected none (cycle %0d)",
                   clks_per_period, volume, cyc);
        end else begin
          e = exp_q.pop_front();
          check("clks_per_period", clks_per_period, e.cpp);
          check("volume", 32'(volume), 32'(e.vol));
          check("signal_present", 32'(signal_present), 32'(e.present));
        end
      end
    end
  end

  task automatic push_exp(input logic [31:0] cpp, input logic [3:0] vol, input logic present);
    exp_t e;
    e.cpp = cpp;
    e.vol = vol;
    e.present = present;
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic v, input int n);
    in_sig = v;
    repeat (n) @(negedge clk);
  endtask

  // Glitch variant: 10 high, 10 low, 2-clk pulse at offset 20 (< MIN_PERIOD, ignored), low to 100.
  task automatic wave_period(input int p, input int h, input bit glitch);
    if (glitch) begin
      drive(1'b1, 10);
      drive(1'b0, 10);
      drive(1'b1, 2);
      drive(1'b0, p - 22);
    end else begin
      drive(1'b1, h);
      drive(1'b0, p - h);
    end
  endtask

  // One arming rise + four measured periods; the 5th rise closes the window.
  task automatic run_window(input int p, input int h, input bit glitch,
                            input logic [31:0] cpp, input logic [3:0] vol, input bit drop_en);
    for (int i = 0; i < 4; i++) wave_period(p, h, glitch);
    push_exp(cpp, vol, 1'b1);
    last_rise_cyc = cyc;
    wave_period(p, h, glitch);
    if (drop_en) begin
      enable = 1'b0;
      drive(1'b0, 3);
      enable = 1'b1;
      drive(1'b0, 2);
    end
  endtask

  // Latency: 3 clks sync+detect, TMO counts to saturate, 1 clk into LOST, 1 clk to register outputs.
  task automatic wait_lost(input string name);
    int unsigned start_cnt;
    start_cnt = valid_count;
    for (int i = 0; i < int'(TMO) + 50; i++) begin
      if (valid_count != start_cnt) break;
      @(negedge clk);
    end
    @(negedge clk);
    check({name, "_pulse_count"}, valid_count - start_cnt, 1);
    check({name, "_latency"}, last_valid_cyc - last_rise_cyc, TMO + 5);
    check({name, "_present_after"}, 32'(signal_present), 0);
  endtask

  initial begin
    repeat (60000) @(posedge clk);
    tests++;
    fails++;
    $display("FAIL watchdog: got cycle budget exhausted, expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    reset  = 1'b1;
    enable = 1'b0;
    in_sig = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset_cpp", clks_per_period, 0);
    check("reset_vol", 32'(volume), 0);
    check("reset_present", 32'(signal_present), 0);
    check("reset_valid", 32'(period_valid), 0);
    enable = 1'b1;
    drive(1'b0, 3);

    // 50%, 25%, 12.5% duty at period 32
    run_window(32, 16, 1'b0, 32, 4'd15, 1'b1);
    run_window(32, 8,  1'b0, 32, 4'd14, 1'b1);
    run_window(32, 4,  1'b0, 32, 4'd13, 1'b1);

    // period 100 with glitch: hi=12/period, 48<<4=768>=400 first at k=3 -> volume 12
    run_window(100, 0, 1'b1, 100, 4'd12, 1'b0);

    // stop toggling: timeout measured from the window-closing rise
    push_exp(0, 4'd0, 1'b0);
    wait_lost("timeout");

    // single arming rise then stuck low
    push_exp(0, 4'd0, 1'b0);
    last_rise_cyc = cyc;
    drive(1'b1, 16);
    in_sig = 1'b0;
    wait_lost("stuck_low");

    run_window(64, 32, 1'b0, 64, 4'd15, 1'b1);

    // enable dropped mid-window: outputs hold, no pulse, re-enable re-arms
    for (int i = 0; i < 3; i++) wave_period(32, 16, 1'b0);
    drive(1'b1, 10);
    enable = 1'b0;
    drive(1'b0, 5);
    check("hold_cpp", clks_per_period, 64);
    check("hold_vol", 32'(volume), 15);
    check("hold_present", 32'(signal_present), 1);
    enable = 1'b1;
    drive(1'b0, 10);
    run_window(32, 16, 1'b0, 32, 4'd15, 1'b1);

    // reset 5 clks into an 8-step duty search (period 200, 1 high -> k=7)
    for (int i = 0; i < 4; i++) wave_period(200, 1, 1'b0);
    drive(1'b1, 1);
    drive(1'b0, 7);
    reset = 1'b1;
    drive(1'b0, 3);
    reset = 1'b0;
    @(negedge clk);
    check("midreset_cpp", clks_per_period, 0);
    check("midreset_vol", 32'(volume), 0);
    check("midreset_present", 32'(signal_present), 0);
    drive(1'b0, 30);
    run_window(32, 16, 1'b0, 32, 4'd15, 1'b1);

    drive(1'b0, 20);
    check("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
